gearbox_12to16: RTL and testbench
=================================

Name: gearbox_12to16

Overview:
Width-converting stream stage that packs a stream of 12-bit words into 16-bit words. It feeds the 16-bit bus whose 12-bit low/high fields are aliased downstream.
- Packs LSB-first: 4 input words produce exactly 3 output words.
- Uses valid/ready handshakes on both sides.
- Supports an explicit flush that pads and emits a final partial word.

Parameters:
PAD_BIT, 1'b0, value written into unfilled bit positions of a flushed partial word
CNT_W, 16, width of the optional output-word counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  block accepts in_data this cycle
in_data  input  12  input word
flush  input  1  request to drain residual bits; single-cycle pulse
flush_done  output  1  one-cycle pulse when flush completes
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  16  packed output word
out_last  output  1  marks the final word of a flush

Behaviour:
- Storage is a 28-bit accumulator acc and a 5-bit fill count (0..27). Bits at and above fill are don't-care.
- Bit order: each accepted word is placed at acc[fill+11:fill]. out_data = acc[15:0] (registered source).
- States: RUN and FLUSH.
- In RUN:
  - out_valid = (fill >= 16). out_last = 0.
  - in_ready = (fill < 16) || out_ready. This path is combinational from out_ready.
  - Output fire: acc shifts right by 16; fill -= 16.
  - Simultaneous in and out fire: shift first, then place the input at the post-shift fill. Resulting fill never exceeds 23.
  - Input fire alone: fill += 12. Maximum fill is 27.
  - Latency: a word completing a 16-bit group is visible on out_data the next cycle.
- Flush:
  - flush in RUN → FLUSH next cycle.
  - An input fire in the same cycle as flush is included before the flush.
  - A flush pulse while already in FLUSH is ignored.
- In FLUSH:
  - in_ready = 0.
  - out_valid = (fill != 0).
  - Emitted word bits [15:fill] are forced to PAD_BIT when fill < 16.
  - out_last = (fill <= 16).
  - On output fire: fill = (fill > 16) ? fill - 16 : 0.
  - When fill == 0: return to RUN and pulse flush_done for one cycle.
  - Flush with fill == 0 on entry: no output; flush_done one cycle after entry.
- out_data/out_valid/out_last are held stable while out_valid && !out_ready.
- Reset values: acc = 0, fill = 0, state RUN, out_valid 0, out_last 0, flush_done 0. in_ready = 1 after reset.
- Reset mid-operation discards all residual bits. The first word after reset starts at bit 0.
- Steady state with out_ready = 1 and in_valid = 1: in_ready stays 1 and the block accepts one word per cycle. Fill sequence is 0, 12, 24→8, 20→4, 16→0 …

Optional Feature:
GB12_WORD_COUNT_EN
- Defined:
  - Adds output port out_count [CNT_W-1:0].
  - Increments on every output fire, including flush words, and wraps modulo 2^CNT_W.
  - Cleared by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Back-to-back, out_ready = 1. Feed 0x123, 0x456, 0x789, 0xABC on consecutive cycles → outputs 0x6123, 0x8945, 0xABC7 in order. in_ready never drops; out_last = 0.
- Backpressure. out_ready = 0, continuous in_valid → only 0x123 and 0x456 are accepted (fill 24), then in_ready = 0. Release out_ready → 0x6123 emitted; input resumes in the same cycle.
- Flush partial. Accept 0x123, then pulse flush → single output 0x0123 with out_last = 1, then flush_done. Repeat with PAD_BIT = 1 → 0xF123.
- Flush with fill > 16. Accept 0x123, 0x456 (fill 24), flush → 0x6123 with out_last = 0, then 0x0045 with out_last = 1, then flush_done. Flush at fill = 0 → no output, flush_done only.
- Reset mid-stream. Accept 0xFFF, assert rst for one cycle → out_valid = 0. Then feed 0x123, 0x456, 0x789, 0xABC → the same three words as the first scenario.
- With GB12_WORD_COUNT_EN and CNT_W = 2. Emit 5 words → out_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/gearbox_12to16.sv
// gearbox_12to16: packs a stream of 12-bit words LSB-first into 16-bit words, with flush/pad of a final partial word.
// Optional build macro GB12_WORD_COUNT_EN adds out_count, a wrapping count of emitted output words.
module gearbox_12to16 #(
    parameter logic PAD_BIT = 1'b0,
    parameter int   CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    input  logic        flush,
    output logic        flush_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last
`ifdef GB12_WORD_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state, state_n;
    logic [27:0] acc, acc_n, acc_sh;
    logic [4:0]  fill, fill_n, fill_sh;
    logic [15:0] pad_mask;
    logic        in_fire, out_fire, flush_done_n;

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    // Handshake outputs and the padded view of the low 16 accumulator bits
    always_comb begin
        in_ready  = (state == RUN) && ((fill < 5'd16) || out_ready);
        out_valid = (state == RUN) ? (fill >= 5'd16) : (fill != 5'd0);
        out_last  = (state == FLUSH) && (fill <= 5'd16);
        pad_mask  = ((state == FLUSH) && (fill < 5'd16)) ? ~((16'd1 << fill) - 16'd1) : 16'd0;
        out_data  = (acc[15:0] & ~pad_mask) | ({16{PAD_BIT}} & pad_mask);
    end

    // Next accumulator: drain an emitted word first, then append the accepted input at the new fill
    always_comb begin
        in_fire      = in_valid && in_ready;
        out_fire     = out_valid && out_ready;
        acc_sh       = out_fire ? {16'd0, acc[27:16]} : acc;
        fill_sh      = !out_fire ? fill : ((fill > 5'd16) ? fill - 5'd16 : 5'd0);
        acc_n        = in_fire ? ((acc_sh & ((28'd1 << fill_sh) - 28'd1)) | ({16'd0, in_data} << fill_sh)) : acc_sh;
        fill_n       = in_fire ? fill_sh + 5'd12 : fill_sh;
        state_n      = (state == RUN) ? (flush ? FLUSH : RUN) : ((fill == 5'd0) ? RUN : FLUSH);
        flush_done_n = (state == FLUSH) && (fill == 5'd0);
    end

    // State, accumulator and flush completion registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            fill       <= fill_n;
            flush_done <= flush_done_n;
        end
    end

`ifdef GB12_WORD_COUNT_EN
    // Wrapping count of every emitted output word, flush words included
    always_ff @(posedge clk) begin
        if (rst)
            out_count <= '0;
        else if (out_fire)
            out_count <= out_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_gearbox_12to16.sv
// tb_gearbox_12to16: randomized and directed bench against a bit-queue reference model.
module tb_gearbox_12to16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_ready0, flush_done0, out_valid0, out_last0;
    logic        in_ready1, flush_done1, out_valid1, out_last1;
    logic [15:0] out_data0, out_data1;
`ifdef GB12_WORD_COUNT_EN
    logic [1:0]  out_count0, out_count1;
`endif

    gearbox_12to16 #(.PAD_BIT(1'b0), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .flush(flush), .flush_done(flush_done0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_last(out_last0)
`ifdef GB12_WORD_COUNT_EN
        , .out_count(out_count0)
`endif
    );

    gearbox_12to16 #(.PAD_BIT(1'b1), .CNT_W(2)) dut_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .flush(flush), .flush_done(flush_done1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1)
`ifdef GB12_WORD_COUNT_EN
        , .out_count(out_count1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        last;
    } word_t;

    int          checks = 0;
    int          passes = 0;
    bit          q[$];
    bit          flushing = 1'b0;
    bit          fd_exp = 1'b0;
    int          cnt = 0;
    int          fd_count = 0;
    int          accepted = 0;
    word_t       log_q[$];
    logic [11:0] pending[$];
    logic [31:0] cnt_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive();
        in_valid = pending.size() != 0;
        in_data  = in_valid ? pending[0] : 12'h000;
    endtask

    task automatic push(input logic [11:0] w);
        pending.push_back(w);
        drive();
    endtask

    // One clock: compare at negedge, advance the model at posedge, then re-drive inputs
    task automatic step();
        int          n;
        bit          e_ready, e_valid, e_last, ifire, ofire, fdn;
        logic [15:0] d0, d1;
        @(negedge clk);
        n       = q.size();
        e_ready = !flushing && (n < 16 || out_ready);
        e_valid = flushing ? (n != 0) : (n >= 16);
        e_last  = flushing && (n <= 16);
        for (int i = 0; i < 16; i++) begin
            d0[i] = (i < n) ? q[i] : 1'b0;
            d1[i] = (i < n) ? q[i] : 1'b1;
        end
        chk("in_ready", in_ready0, e_ready);
        chk("out_valid", out_valid0, e_valid);
        chk("flush_done", flush_done0, fd_exp);
        chk("in_ready_p1", in_ready1, e_ready);
        chk("out_valid_p1", out_valid1, e_valid);
        chk("flush_done_p1", flush_done1, fd_exp);
        if (e_valid) begin
            chk("out_data", out_data0, d0);
            chk("out_last", out_last0, e_last);
            chk("out_data_p1", out_data1, d1);
            chk("out_last_p1", out_last1, e_last);
        end
`ifdef GB12_WORD_COUNT_EN
        chk("out_count", out_count0, cnt % 4);
        chk("out_count_p1", out_count1, cnt % 4);
`endif
        ifire = in_valid && e_ready;
        ofire = e_valid && out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            flushing = 1'b0;
            fd_exp   = 1'b0;
            cnt      = 0;
        end else begin
            fdn = flushing && (n == 0);
            if (ofire) begin
                for (int i = 0; i < 16 && q.size() > 0; i++) void'(q.pop_front());
                cnt++;
                log_q.push_back('{d0, d1, e_last});
            end
            if (ifire) begin
                for (int i = 0; i < 12; i++) q.push_back(in_data[i]);
                accepted++;
                void'(pending.pop_front());
            end
            if (!flushing && flush) flushing = 1'b1;
            else if (flushing && n == 0) flushing = 1'b0;
            fd_exp = fdn;
            if (fdn) fd_count++;
        end
        #1;
`ifdef GB12_WORD_COUNT_EN
        if (ofire && !rst) cnt_log.push_back(32'(out_count0));
`endif
        drive();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic chk_word(input string name, input int idx, input logic [15:0] d0, input logic [15:0] d1, input logic last);
        if (idx < log_q.size()) begin
            chk({name, "_d0"}, log_q[idx].d0, d0);
            chk({name, "_d1"}, log_q[idx].d1, d1);
            chk({name, "_last"}, log_q[idx].last, last);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int a0;
        run(2);
        rst = 1'b0;
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_last", out_last0, 0);
        chk("rst_flush_done", flush_done0, 0);

        // back-to-back
        out_ready = 1'b1;
        log_q.delete();
        accepted = 0;
        push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
        run(4);
        chk("s1_accept_4", accepted, 4);
        run(4);
        chk("s1_count", log_q.size(), 3);
        chk_word("s1_w0", 0, 16'h6123, 16'h6123, 1'b0);
        chk_word("s1_w1", 1, 16'h8945, 16'h8945, 1'b0);
        chk_word("s1_w2", 2, 16'hABC7, 16'hABC7, 1'b0);

        // backpressure
        log_q.delete();
        accepted  = 0;
        out_ready = 1'b0;
        push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
        run(4);
        chk("s2_accepted", accepted, 2);
        chk("s2_in_ready_low", in_ready0, 0);
        out_ready = 1'b1;
        a0 = accepted;
        step();
        chk("s2_resume", accepted - a0, 1);
        chk("s2_first", log_q.size(), 1);
        run(6);
        chk("s2_count", log_q.size(), 3);
        chk_word("s2_w0", 0, 16'h6123, 16'h6123, 1'b0);
        chk_word("s2_w1", 1, 16'h8945, 16'h8945, 1'b0);
        chk_word("s2_w2", 2, 16'hABC7, 16'hABC7, 1'b0);

        // flush partial
        log_q.delete();
        fd_count = 0;
        push(12'h123);
        step();
        pulse_flush();
        run(5);
        chk("s3_count", log_q.size(), 1);
        chk_word("s3_w0", 0, 16'h0123, 16'hF123, 1'b1);
        chk("s3_done", fd_count, 1);

        // flush with fill above 16
        log_q.delete();
        fd_count = 0;
        push(12'h123); push(12'h456);
        run(2);
        pulse_flush();
        run(6);
        chk("s4_count", log_q.size(), 2);
        chk_word("s4_w0", 0, 16'h6123, 16'h6123, 1'b0);
        chk_word("s4_w1", 1, 16'h0045, 16'hFF45, 1'b1);
        chk("s4_done", fd_count, 1);

        // flush when empty
        log_q.delete();
        fd_count = 0;
        pulse_flush();
        run(4);
        chk("s4e_count", log_q.size(), 0);
        chk("s4e_done", fd_count, 1);

        // reset mid-stream
        push(12'hFFF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_out_valid", out_valid0, 0);
        chk("s5_in_ready", in_ready0, 1);
        log_q.delete();
        push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
        run(8);
        chk("s5_count", log_q.size(), 3);
        chk_word("s5_w0", 0, 16'h6123, 16'h6123, 1'b0);
        chk_word("s5_w1", 1, 16'h8945, 16'h8945, 1'b0);
        chk_word("s5_w2", 2, 16'hABC7, 16'hABC7, 1'b0);

`ifdef GB12_WORD_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt_log.delete();
        for (int i = 0; i < 7; i++) push(12'(i * 301 + 5));
        run(12);
        chk("cnt_len", cnt_log.size(), 5);
        if (cnt_log.size() == 5) begin
            chk("cnt_0", cnt_log[0], 1);
            chk("cnt_1", cnt_log[1], 2);
            chk("cnt_2", cnt_log[2], 3);
            chk("cnt_3", cnt_log[3], 0);
            chk("cnt_4", cnt_log[4], 1);
        end
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (pending.size() == 0 && $urandom_range(0, 1) == 1) push(12'($urandom));
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        flush = 1'b0;
        rst   = 1'b0;
        out_ready = 1'b1;
        run(10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
